// File: rtl/data_bus_arb_pkg.sv
// Shared constants and state encoding for the round-robin 64-bit data bus arbiter.
package data_bus_arb_pkg;

   localparam int DW            = 64;
   localparam int NREQ_DEF      = 4;
   localparam int MAX_BURST_DEF = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
   import data_bus_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         cand = sum[PW-1:0];
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/data_bus_arb.sv
// Round-robin burst arbiter for a shared 64-bit data bus with registered grant/data.
module data_bus_arb
   import data_bus_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic               clk,
   input  logic               rst_all,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    last,
   input  logic [DW*NREQ-1:0] data_i,
   output logic [NREQ-1:0]    gnt,
   output logic [DW-1:0]      data_o,
   output logic               valid_o,
   output logic               busy
);

   localparam int PW = idx_w(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_e          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [PW-1:0]   own_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   ptr_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [DW-1:0]   data_q;
   logic            valid_q;
   logic            busy_q;

   logic [DW-1:0]   lane [NREQ];
   logic [NREQ-1:0] pick_gnt;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            own_req;
   logic            own_last;
   logic            burst_end;
   logic            release_now;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane[g] = data_i[g*DW +: DW];
   end

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      own_req     = req[own_q];
      own_last    = last[own_q];
      cnt_d       = cnt_q + 1'b1;
      burst_end   = (cnt_d == CW'(MAX_BURST));
      release_now = !own_req || own_last || burst_end;
      ptr_d       = (own_q == PW'(NREQ-1)) ? '0 : own_q + 1'b1;
   end

   // The releasing beat is still driven out; only the grant drops with it.
   always_ff @(posedge clk) begin
      if (rst_all) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         own_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               if (pick_any) begin
                  gnt_q   <= pick_gnt;
                  own_q   <= pick_idx;
                  state_q <= S_OWN;
                  busy_q  <= 1'b1;
               end
            end
            S_OWN: begin
               valid_q <= own_req;
               if (own_req) begin
                  data_q <= lane[own_q];
               end
               if (release_now) begin
                  gnt_q   <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  ptr_q   <= ptr_d;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign busy    = busy_q;

   a_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
   a_cnt:    assert property (@(posedge clk) cnt_q < CW'(MAX_BURST));

endmodule

// File: tb/tb_data_bus_arb.sv
// Scoreboard bench for data_bus_arb: scripted requesters, expected beats/grants queued.
module tb_data_bus_arb;

   localparam int NREQ = 4;
   localparam int MAXB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_all;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    last;
   logic [64*NREQ-1:0] data_i;
   logic [NREQ-1:0]    gnt;
   logic [63:0]        data_o;
   logic               valid_o;
   logic               busy;

   data_bus_arb #(
      .NREQ      (NREQ),
      .MAX_BURST (MAXB)
   ) dut (
      .clk     (clk),
      .rst_all (rst_all),
      .req     (req),
      .last    (last),
      .data_i  (data_i),
      .gnt     (gnt),
      .data_o  (data_o),
      .valid_o (valid_o),
      .busy    (busy)
   );

   int pass_cnt = 0;
   int tot_cnt  = 0;

   int          nb   [NREQ];
   int          pos  [NREQ];
   int          lat  [NREQ];
   logic [63:0] base [NREQ];
   logic [63:0] step [NREQ];

   logic [63:0]     exp_q [$];
   logic [NREQ-1:0] gq    [$];

   logic [63:0]     last_data;
   logic [NREQ-1:0] prev_gnt;
   int              gap;
   bit              have_rel;
   bit              strict_gap;
   int              vcnt;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tot_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] tag(input int scn, input int i);
      return (64'(scn) << 56) | (64'(i) << 48);
   endfunction

   function automatic logic [63:0] beat(input int i, input int k);
      return base[i] + 64'(k) * step[i];
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req[i]  = pos[i] < nb[i];
         last[i] = (pos[i] == lat[i]) && (pos[i] < nb[i]);
         data_i[i*64 +: 64] = beat(i, pos[i]);
      end
   endtask

   task automatic load(input int i, input int n, input logic [63:0] b,
                       input logic [63:0] s, input int la);
      nb[i]   = n;
      pos[i]  = 0;
      base[i] = b;
      step[i] = s;
      lat[i]  = la;
   endtask

   task automatic push_beats(input int i, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) exp_q.push_back(beat(i, k));
   endtask

   task automatic tick();
      logic [NREQ-1:0] cons;
      logic [NREQ-1:0] eg;
      logic [63:0]     ed;
      logic            rst_pre;
      cons    = gnt & req;
      rst_pre = rst_all;
      @(posedge clk);
      #1;
      if (rst_pre) begin
         chk("rst_gnt",   64'(gnt),     64'(0));
         chk("rst_valid", 64'(valid_o), 64'(0));
         chk("rst_busy",  64'(busy),    64'(0));
         chk("rst_data",  data_o,       64'(0));
         last_data = '0;
         prev_gnt  = '0;
         gap       = 0;
         have_rel  = 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) if (cons[i]) pos[i]++;
         if (valid_o) begin
            vcnt++;
            if (exp_q.size() == 0) begin
               chk("sb_extra_beat", 64'(valid_o), 64'(0));
            end else begin
               ed = exp_q.pop_front();
               chk("sb_data", data_o, ed);
            end
            last_data = data_o;
         end else begin
            chk("data_hold", data_o, last_data);
         end
         chk("onehot", 64'($onehot0(gnt)), 64'(1));
         chk("busy_own", 64'(busy), 64'(gnt != '0));
         if (gnt != '0 && prev_gnt == '0) begin
            if (gq.size() == 0) begin
               chk("gnt_extra", 64'(gnt), 64'(0));
            end else begin
               eg = gq.pop_front();
               chk("gnt_order", 64'(gnt), 64'(eg));
            end
            if (strict_gap && have_rel) chk("turnaround", 64'(gap), 64'(1));
         end
         if (gnt != '0 && prev_gnt != '0) begin
            chk("no_preempt", 64'(gnt), 64'(prev_gnt));
         end
         if (gnt == '0) begin
            if (prev_gnt != '0) begin
               have_rel = 1'b1;
               gap      = 0;
            end
            gap++;
         end
         prev_gnt = gnt;
      end
      drive();
   endtask

   function automatic bit quiet();
      bit d = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pos[i] < nb[i]) d = 1'b0;
      return d && gnt == '0 && !valid_o && !busy &&
             exp_q.size() == 0 && gq.size() == 0;
   endfunction

   task automatic run_idle();
      int n = 0;
      while (!quiet() && n < 400) begin
         tick();
         n++;
      end
      chk("idle_reached", 64'(quiet()), 64'(1));
      chk("sb_drained", 64'(exp_q.size() + gq.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_all    = 1'b1;
      last_data  = '0;
      prev_gnt   = '0;
      gap        = 0;
      have_rel   = 1'b0;
      strict_gap = 1'b0;
      vcnt       = 0;
      req        = '0;
      last       = '0;
      data_i     = '0;
      for (int i = 0; i < NREQ; i++) load(i, 0, 64'(0), 64'(0), -1);
      drive();
      tick();
      tick();
      rst_all = 1'b0;

      // single requester, last on third beat
      load(0, 3, 64'h11, 64'h11, 2);
      gq.push_back(4'b0001);
      push_beats(0, 0, 2);
      drive();
      tick();
      chk("t28_gnt_c1",   64'(gnt),     64'(4'b0001));
      chk("t28_valid_c1", 64'(valid_o), 64'(0));
      tick();
      chk("t28_valid_c2", 64'(valid_o), 64'(1));
      tick();
      tick();
      chk("t28_gnt_c4",   64'(gnt),     64'(0));
      chk("t28_valid_c4", 64'(valid_o), 64'(1));
      chk("t28_data_c4",  data_o,       64'h33);
      tick();
      chk("t28_busy_c5",  64'(busy),    64'(0));
      chk("t28_valid_c5", 64'(valid_o), 64'(0));
      run_idle();

      // all four requesting, bursts capped at MAXB
      rst_all = 1'b1;
      tick();
      rst_all = 1'b0;
      strict_gap = 1'b1;
      for (int i = 0; i < NREQ; i++) load(i, 2*MAXB, tag(29, i), 64'(1), -1);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            gq.push_back(NREQ'(1) << i);
            push_beats(i, r*MAXB, r*MAXB + MAXB - 1);
         end
      end
      drive();
      run_idle();
      strict_gap = 1'b0;

      // move ptr to 1, then 0101 must serve requester 2 first
      load(0, 1, tag(30, 0), 64'(1), 0);
      gq.push_back(4'b0001);
      push_beats(0, 0, 0);
      drive();
      run_idle();
      load(0, 2, tag(30, 0) | 64'h1000, 64'(1), 1);
      load(2, 3, tag(30, 2), 64'(1), 2);
      gq.push_back(4'b0100);
      gq.push_back(4'b0001);
      push_beats(2, 0, 2);
      push_beats(0, 0, 1);
      drive();
      run_idle();

      // requester 2 drops req after two beats; ptr must move to 3
      load(2, 2, tag(31, 2), 64'(1), -1);
      gq.push_back(4'b0100);
      push_beats(2, 0, 1);
      drive();
      run_idle();
      load(1, 2, tag(31, 1), 64'(1), 1);
      load(2, 2, tag(31, 2) | 64'h1000, 64'(1), 1);
      gq.push_back(4'b0010);
      gq.push_back(4'b0100);
      push_beats(1, 0, 1);
      push_beats(2, 0, 1);
      drive();
      run_idle();

      // reset in the middle of a burst
      vcnt = 0;
      load(0, MAXB, tag(32, 0), 64'(1), -1);
      gq.push_back(4'b0001);
      push_beats(0, 0, 3);
      drive();
      n = 0;
      while (vcnt < 4 && n < 50) begin
         tick();
         n++;
      end
      chk("t32_reach_beat4", 64'(vcnt), 64'(4));
      rst_all = 1'b1;
      nb[0]   = 0;
      drive();
      tick();
      rst_all = 1'b0;
      chk("t32_sb_empty", 64'(exp_q.size() + gq.size()), 64'(0));
      load(1, 2, tag(32, 1), 64'(1), 1);
      load(3, 2, tag(32, 3), 64'(1), 1);
      gq.push_back(4'b0010);
      gq.push_back(4'b1000);
      push_beats(1, 0, 1);
      push_beats(3, 0, 1);
      drive();
      tick();
      chk("t32_ptr0_gnt", 64'(gnt), 64'(4'b0010));
      run_idle();

      // single beat with last set
      load(1, 1, tag(33, 1), 64'(1), 0);
      gq.push_back(4'b0010);
      push_beats(1, 0, 0);
      drive();
      tick();
      chk("t33_gnt",    64'(gnt),     64'(4'b0010));
      tick();
      chk("t33_valid",  64'(valid_o), 64'(1));
      chk("t33_rel",    64'(gnt),     64'(0));
      chk("t33_busy",   64'(busy),    64'(0));
      tick();
      chk("t33_valid2", 64'(valid_o), 64'(0));
      chk("t33_busy2",  64'(busy),    64'(0));
      run_idle();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/data_bus_arb.md
DATA_BUS_ARB -- requirements
Module: data_bus_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing the 64-bit data bus.
REQ-002 The block SHALL have parameter MAX_BURST, default 8, meaning maximum beats per grant before forced release.
REQ-003 Port clk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_all, input, 1, meaning synchronous active-high reset.
REQ-005 Port req, input, NREQ, meaning per-requester request; held high while the requester has beats.
REQ-006 Port last, input, NREQ, meaning per-requester final-beat flag, qualified by req.
REQ-007 Port data_i, input, 64*NREQ, meaning requester i data at bits [64*i+63:64*i].
REQ-008 Port gnt, output, NREQ, meaning one-hot registered grant.
REQ-009 Port data_o, output, 64, meaning registered bus data.
REQ-010 Port valid_o, output, 1, meaning data_o carries a beat this cycle.
REQ-011 Port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-012 FSM SHALL have states IDLE and OWN only.
REQ-013 IDLE: if any req bit high, SHALL register gnt one-hot to the winner and move to OWN; else stay, gnt=0.
REQ-014 Winner SHALL be the first set req bit searching upward from pointer ptr, wrapping from NREQ-1 to 0.
REQ-015 OWN: each cycle with req[w] high, SHALL register data_o=data_i[w], valid_o=1, beat counter +1.
REQ-016 OWN: cycle with req[w] low SHALL produce valid_o=0 and release the grant.
REQ-017 Release SHALL occur on the beat with last[w]=1, on req[w] low, or on the beat making count equal MAX_BURST, whichever first.
REQ-018 On release: gnt<=0, state<=IDLE, ptr<=(w+1) mod NREQ, beat counter<=0; the released beat itself is still output.
REQ-019 Grant-to-first-data latency SHALL be one cycle: gnt high in cycle n, first valid_o in cycle n+1.
REQ-020 At least one IDLE cycle SHALL separate consecutive grants (bus turnaround).
REQ-021 Requests from non-granted requesters SHALL be ignored until IDLE; no preemption.
REQ-022 Beat counter SHALL be ceil(log2(MAX_BURST+1)) bits and never wrap.
REQ-023 data_o SHALL hold its last value when valid_o=0.

Reset
REQ-024 rst_all SHALL set state=IDLE, gnt=0, valid_o=0, busy=0, data_o=0, ptr=0, counter=0 at the next edge, overriding any in-progress burst.
REQ-025 The cycle after rst_all deasserts SHALL arbitrate normally from ptr=0.

Structure
REQ-026 Shared package SHALL hold NREQ/MAX_BURST defaults, data width 64, and the state encoding.
REQ-027 The round-robin pick (req, ptr -> one-hot winner, any) SHALL be a sub-module rr_pick, purely combinational.

Verification
REQ-028 Reset, req=0001, last on 3rd beat, data 0x11,0x22,0x33 -> gnt=0001 at cycle 1, valid_o cycles 2-4 with 0x11,0x22,0x33, busy low cycle 5.
REQ-029 req=1111 held, no last -> grants 0001,0010,0100,1000,0001 in order, each exactly 8 beats, one idle cycle between.
REQ-030 req=0101, ptr=1 -> requester 2 granted first, then requester 0.
REQ-031 Granted requester drops req after 2 beats -> 2 valid beats, grant released, ptr advances.
REQ-032 rst_all asserted at beat 4 of a burst -> next cycle gnt=0, valid_o=0, data_o=0, ptr=0.
REQ-033 req=0010 with last=0010 on first beat -> exactly one valid beat, then IDLE.
